// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel push-button synchroniser, debouncer, hold and auto-repeat front end
module button_conditioner #(
    parameter int CHANNELS        = 7,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 8388608,
    parameter int REPEAT_CYCLES   = 2500000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                clk_25mhz,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] held,
    output logic [CHANNELS-1:0] repeat_pulse,
    output logic [CHANNELS-1:0] toggle
);

    localparam int DW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TIMER_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW        = $clog2(TIMER_MAX + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

    localparam logic [1:0] ST_RELEASED = 2'd0;
    localparam logic [1:0] ST_PRESSED  = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] release_q, release_d;
    logic [CHANNELS-1:0] held_q, held_d;
    logic [CHANNELS-1:0] repeat_q, repeat_d;
    logic [CHANNELS-1:0] toggle_q, toggle_d;
    logic [CHANNELS-1:0] rise, fall;

    logic [DW-1:0] deb_cnt_q [CHANNELS];
    logic [DW-1:0] deb_cnt_d [CHANNELS];
    logic [TW-1:0] timer_q   [CHANNELS];
    logic [TW-1:0] timer_d   [CHANNELS];
    logic [1:0]    state_q   [CHANNELS];
    logic [1:0]    state_d   [CHANNELS];

    // Polarity is folded in before the synchroniser so that zero is always the idle level.
    always_comb begin
        sync1_d = btn ^ {CHANNELS{ACTIVE_LOW}};
        sync2_d = sync1_q;
        for (int i = 0; i < CHANNELS; i++) begin
            level_d[i]   = level_q[i];
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        rise      = level_d & ~level_q;
        fall      = ~level_d & level_q;
        press_d   = rise;
        release_d = fall;
        toggle_d  = toggle_q ^ press_q;
    end

    // A falling level always takes priority over hold entry or a repeat expiry on the same cycle.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]  = state_q[i];
            timer_d[i]  = timer_q[i];
            repeat_d[i] = 1'b0;
            case (state_q[i])
                ST_RELEASED: begin
                    if (rise[i]) begin
                        state_d[i] = ST_PRESSED;
                        timer_d[i] = '0;
                    end
                end
                ST_PRESSED: begin
                    if (fall[i]) begin
                        state_d[i] = ST_RELEASED;
                        timer_d[i] = '0;
                    end else if (timer_q[i] == HOLD_LAST) begin
                        state_d[i]  = ST_HELD;
                        timer_d[i]  = '0;
                        repeat_d[i] = 1'b1;
                    end else begin
                        timer_d[i] = timer_q[i] + TW'(1);
                    end
                end
                ST_HELD: begin
                    if (fall[i]) begin
                        state_d[i] = ST_RELEASED;
                        timer_d[i] = '0;
                    end else if (REPEAT_CYCLES > 0) begin
                        if (timer_q[i] == REP_LAST) begin
                            timer_d[i]  = '0;
                            repeat_d[i] = 1'b1;
                        end else begin
                            timer_d[i] = timer_q[i] + TW'(1);
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_RELEASED;
                    timer_d[i] = '0;
                end
            endcase
            held_d[i] = (state_d[i] == ST_HELD);
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            held_q    <= '0;
            repeat_q  <= '0;
            toggle_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                deb_cnt_q[i] <= '0;
                timer_q[i]   <= '0;
                state_q[i]   <= ST_RELEASED;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            held_q    <= held_d;
            repeat_q  <= repeat_d;
            toggle_q  <= toggle_d;
            for (int i = 0; i < CHANNELS; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
                timer_q[i]   <= timer_d[i];
                state_q[i]   <= state_d[i];
            end
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign held          = held_q;
    assign repeat_pulse  = repeat_q;
    assign toggle        = toggle_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed vector bench for button_conditioner
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] btn1, btn2;
    logic [2:0] level1, press1, rel1, held1, rpt1, tog1;
    logic [2:0] level2, press2, rel2, held2, rpt2, tog2;

    int checks   = 0;
    int failures = 0;

    logic [2:0] prs_seen, rel_seen, rpt_seen;
    logic [2:0] dut2_any;

    always #20 clk = ~clk;

    button_conditioner #(
        .CHANNELS(3), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .ACTIVE_LOW(1'b0)
    ) dut_hi (
        .clk_25mhz(clk), .reset(reset), .btn(btn1),
        .level(level1), .press(press1), .release_pulse(rel1),
        .held(held1), .repeat_pulse(rpt1), .toggle(tog1)
    );

    button_conditioner #(
        .CHANNELS(3), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .ACTIVE_LOW(1'b1)
    ) dut_lo (
        .clk_25mhz(clk), .reset(reset), .btn(btn2),
        .level(level2), .press(press2), .release_pulse(rel2),
        .held(held2), .repeat_pulse(rpt2), .toggle(tog2)
    );

    typedef struct {
        logic [2:0] btn;
        int         n;
        logic [2:0] lvl;
        logic [2:0] prs;
        logic [2:0] rel;
        logic [2:0] hld;
        logic [2:0] rpt;
        logic [2:0] tog;
        logic [2:0] tmask;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [2:0] b, int n, logic [2:0] lvl, logic [2:0] prs,
                                logic [2:0] rel, logic [2:0] hld, logic [2:0] rpt,
                                logic [2:0] tog, logic [2:0] tmask);
        vec_t v;
        v.btn = b; v.n = n; v.lvl = lvl; v.prs = prs; v.rel = rel;
        v.hld = hld; v.rpt = rpt; v.tog = tog; v.tmask = tmask;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        prs_seen |= press1;
        rel_seen |= rel1;
        rpt_seen |= rpt1;
        dut2_any |= press2 | rel2 | rpt2 | held2;
    endtask

    initial begin
        reset = 1'b1;
        btn1  = 3'b000;
        btn2  = 3'b111;
        prs_seen = '0; rel_seen = '0; rpt_seen = '0; dut2_any = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {level1, press1, rel1, held1, rpt1, tog1}, 18'd0);
        reset    = 1'b0;
        dut2_any = '0;

        // press/release on ch0
        tbl.push_back(mk(3'b001, 5, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111));
        tbl.push_back(mk(3'b001, 1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b110));
        tbl.push_back(mk(3'b001, 1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b111));
        tbl.push_back(mk(3'b001, 3, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b111));
        tbl.push_back(mk(3'b000, 5, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b111));
        tbl.push_back(mk(3'b000, 1, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 3'b111));
        tbl.push_back(mk(3'b000, 1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b111));
        // bounce on ch1 never reaches 4 stable cycles
        for (int k = 0; k < 10; k++) begin
            tbl.push_back(mk(3'b010, 3, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b111));
            tbl.push_back(mk(3'b000, 1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b111));
        end
        tbl.push_back(mk(3'b000, 8, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b111));
        // all channels together, then ch1 released alone
        tbl.push_back(mk(3'b111, 5, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b111));
        tbl.push_back(mk(3'b111, 1, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000));
        tbl.push_back(mk(3'b111, 1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b110, 3'b111));
        tbl.push_back(mk(3'b101, 5, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b110, 3'b111));
        tbl.push_back(mk(3'b101, 1, 3'b101, 3'b000, 3'b010, 3'b000, 3'b000, 3'b110, 3'b111));
        tbl.push_back(mk(3'b000, 6, 3'b000, 3'b000, 3'b101, 3'b000, 3'b000, 3'b110, 3'b111));

        foreach (tbl[v]) begin
            btn1 = tbl[v].btn;
            prs_seen = '0; rel_seen = '0; rpt_seen = '0;
            for (int c = 0; c < tbl[v].n; c++) step();
            chk($sformatf("vec%0d_level", v), level1, tbl[v].lvl);
            chk($sformatf("vec%0d_press", v), prs_seen, tbl[v].prs);
            chk($sformatf("vec%0d_release", v), rel_seen, tbl[v].rel);
            chk($sformatf("vec%0d_held", v), held1, tbl[v].hld);
            chk($sformatf("vec%0d_repeat", v), rpt_seen, tbl[v].rpt);
            chk($sformatf("vec%0d_toggle", v), tog1 & tbl[v].tmask, tbl[v].tog & tbl[v].tmask);
        end

        // long hold on ch2; release lands on a repeat expiry at cycle 66
        btn1 = 3'b100;
        for (int c = 1; c <= 70; c++) begin
            logic exp_rpt;
            if (c == 61) btn1 = 3'b000;
            step();
            exp_rpt = (c == 26 || c == 34 || c == 42 || c == 50 || c == 58);
            chk($sformatf("hold_c%0d", c), {press1[2], held1[2], rpt1[2], rel1[2]},
                {c == 6, (c >= 26 && c < 66), exp_rpt, c == 66});
        end

        // reset while held, button kept down
        btn1 = 3'b100;
        for (int c = 0; c < 30; c++) step();
        chk("held_before_reset", {level1, held1}, {3'b100, 3'b100});
        reset = 1'b1;
        step();
        chk("reset_midrun", {level1, press1, rel1, held1, rpt1, tog1}, 18'd0);
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk($sformatf("repress_c%0d", c), {level1, press1, rel1},
                {(c >= 6) ? 3'b100 : 3'b000, (c == 6) ? 3'b100 : 3'b000, 3'b000});
        end
        chk("repress_toggle", tog1, 3'b100);

        // active-low instance idling high the whole run
        chk("al_idle_pulses", dut2_any, 3'b000);
        chk("al_idle_level", level2, 3'b000);
        btn2 = 3'b110;
        for (int c = 1; c <= 6; c++) begin
            step();
            chk($sformatf("al_press_c%0d", c), {level2, press2},
                (c == 6) ? {3'b001, 3'b001} : 6'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
